// File: rtl/bfp_pkg.sv
// Shared widths, FSM state encoding and result layout for the BFP dot-product engine.
package bfp_pkg;
  localparam int MANT_W = 8;
  localparam int ACC_W  = 32;
  localparam int SF_W   = 24;
  localparam int EXP_W  = 6;

  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = -ACC_MAX;

  typedef enum logic [1:0] {IDLE, ACCUM, NORM, OUT} state_t;

  typedef struct packed {
    logic [SF_W-1:0]  sign_frac;
    logic [EXP_W-1:0] exp;
    logic             ovf;
  } bfp_result_t;
endpackage

// File: rtl/bfp_sm_multiplier.sv
// Sign-magnitude x sign-magnitude multiply, widened to a signed accumulator-width product.
module bfp_sm_multiplier #(
  parameter int MANT_W = bfp_pkg::MANT_W,
  parameter int ACC_W  = bfp_pkg::ACC_W
) (
  input  logic [MANT_W-1:0]       a,
  input  logic [MANT_W-1:0]       b,
  output logic signed [ACC_W-1:0] product
);
  logic [2*MANT_W-3:0] mag;
  logic [ACC_W-1:0]    mag_w;

  always_comb begin
    mag     = a[MANT_W-2:0] * b[MANT_W-2:0];
    mag_w   = ACC_W'(mag);
    product = (a[MANT_W-1] ^ b[MANT_W-1]) ? -mag_w : mag_w;
  end
endmodule

// File: rtl/bfp_dot_accumulator.sv
// Streaming BFP dot product: saturating accumulate, right-shift normalise into {sign,frac}+exp.
module bfp_dot_accumulator #(
  parameter int MANT_W = bfp_pkg::MANT_W,
  parameter int ACC_W  = bfp_pkg::ACC_W,
  parameter int SF_W   = bfp_pkg::SF_W,
  parameter int EXP_W  = bfp_pkg::EXP_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [EXP_W-1:0]  in_exp_a,
  input  logic [EXP_W-1:0]  in_exp_b,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [MANT_W-1:0] in_a,
  input  logic [MANT_W-1:0] in_b,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [SF_W-1:0]   out_sign_frac,
  output logic [EXP_W-1:0]  out_exp,
  output logic              out_ovf,
  output logic              busy
);
  import bfp_pkg::*;

  // Two spare bits so normalisation increments on a max exponent sum cannot wrap.
  localparam int EXW = EXP_W + 2;
  localparam logic signed [ACC_W-1:0] SAT_HI = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_LO = -SAT_HI;
  localparam logic [ACC_W-1:0] MAG_LIM = ACC_W'(1) << (SF_W-1);
  localparam logic [EXW-1:0]   EXP_MAX = EXW'((1 << EXP_W) - 1);

  state_t                  state;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] prod;
  logic signed [ACC_W:0]   sum_w;
  logic                    sat_hi, sat_lo;
  logic                    ovf, sign, norm_first;
  logic [EXW-1:0]          exp_sum;
  logic [ACC_W-1:0]        mag;

  bfp_sm_multiplier #(.MANT_W(MANT_W), .ACC_W(ACC_W)) u_mul (
    .a       (in_a),
    .b       (in_b),
    .product (prod)
  );

  always_comb begin
    sum_w  = {acc[ACC_W-1], acc} + {prod[ACC_W-1], prod};
    sat_hi = sum_w > $signed({1'b0, SAT_HI});
    sat_lo = sum_w < $signed({1'b1, SAT_LO});
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      in_ready      <= 1'b0;
      out_valid     <= 1'b0;
      out_ovf       <= 1'b0;
      busy          <= 1'b0;
      out_sign_frac <= '0;
      out_exp       <= '0;
      acc           <= '0;
      ovf           <= 1'b0;
      sign          <= 1'b0;
      norm_first    <= 1'b0;
      exp_sum       <= '0;
      mag           <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          exp_sum  <= EXW'(in_exp_a) + EXW'(in_exp_b);
          acc      <= '0;
          ovf      <= 1'b0;
          in_ready <= 1'b1;
          busy     <= 1'b1;
          state    <= ACCUM;
        end
        ACCUM: if (in_valid && in_ready) begin
          acc <= sat_hi ? SAT_HI : (sat_lo ? SAT_LO : sum_w[ACC_W-1:0]);
          if (sat_hi || sat_lo) ovf <= 1'b1;
          if (in_last) begin
            in_ready   <= 1'b0;
            norm_first <= 1'b1;
            state      <= NORM;
          end
        end
        NORM: begin
          if (norm_first) begin
            norm_first <= 1'b0;
            sign       <= acc[ACC_W-1] && (acc != '0);
            mag        <= acc[ACC_W-1] ? ACC_W'(-acc) : ACC_W'(acc);
          end else if (mag >= MAG_LIM) begin
            mag     <= mag >> 1;
            exp_sum <= exp_sum + 1'b1;
          end else begin
            out_sign_frac <= {sign, mag[SF_W-2:0]};
            if (exp_sum > EXP_MAX) begin
              out_exp <= '1;
              out_ovf <= 1'b1;
            end else begin
              out_exp <= exp_sum[EXP_W-1:0];
              out_ovf <= ovf;
            end
            out_valid <= 1'b1;
            state     <= OUT;
          end
        end
        OUT: if (out_ready) begin
          out_valid <= 1'b0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_bfp_dot_accumulator.sv
// Directed scoreboard bench for bfp_dot_accumulator.
module tb_bfp_dot_accumulator;
  import bfp_pkg::*;

  logic clk = 1'b0, rst = 1'b1, start = 1'b0, in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b1;
  logic [EXP_W-1:0]  in_exp_a = '0, in_exp_b = '0;
  logic [MANT_W-1:0] in_a = '0, in_b = '0;
  logic              in_ready, out_valid, out_ovf, busy;
  logic [SF_W-1:0]   out_sign_frac;
  logic [EXP_W-1:0]  out_exp;

  int n_tests = 0;
  int n_fail  = 0;
  bfp_result_t sb[$];

  always #5 clk = ~clk;

  bfp_dot_accumulator dut (
    .clk(clk), .rst(rst), .start(start), .in_exp_a(in_exp_a), .in_exp_b(in_exp_b),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_sign_frac(out_sign_frac),
    .out_exp(out_exp), .out_ovf(out_ovf), .busy(busy)
  );

  function automatic logic [MANT_W-1:0] sm(int v);
    logic [MANT_W-2:0] m;
    m = (MANT_W-1)'(v < 0 ? -v : v);
    return {(v < 0), m};
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] want);
    n_tests++;
    assert (obs === want) else begin
      n_fail++;
      $error("FAIL %s: got %0d want %0d", tag, obs, want);
    end
  endtask

  task automatic push_exp(bit s, int frac, int e, bit o);
    bfp_result_t r;
    r.sign_frac = {s, (SF_W-1)'(frac)};
    r.exp       = EXP_W'(e);
    r.ovf       = o;
    sb.push_back(r);
  endtask

  task automatic begin_vec(int ea, int eb);
    @(negedge clk);
    start = 1'b1; in_exp_a = EXP_W'(ea); in_exp_b = EXP_W'(eb);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_pair(int a, int b, bit last);
    int n = 0;
    @(negedge clk);
    in_a = sm(a); in_b = sm(b); in_last = last; in_valid = 1'b1;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) chk("in_ready_timeout", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  // Called right after the last pair's accepting edge; want_lat < 0 skips the latency check.
  task automatic collect(string tag, int want_lat, bit ack);
    bfp_result_t r;
    int cyc = 0;
    do begin
      @(posedge clk); #1;
      cyc++;
    end while (!out_valid && cyc < 60);
    if (!out_valid) begin
      chk({tag, "_out_timeout"}, 64'(out_valid), 64'd1);
      return;
    end
    if (want_lat >= 0) chk({tag, "_latency"}, 64'(cyc), 64'(want_lat));
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 64'(sb.size()), 64'd1);
      return;
    end
    r = sb.pop_front();
    chk({tag, "_sign_frac"}, 64'(out_sign_frac), 64'(r.sign_frac));
    chk({tag, "_exp"},       64'(out_exp),       64'(r.exp));
    chk({tag, "_ovf"},       64'(out_ovf),       64'(r.ovf));
    if (ack) begin
      @(posedge clk); #1;
      chk({tag, "_valid_drop"}, 64'(out_valid), 64'd0);
    end
  endtask

  initial begin
    logic [SF_W-1:0]  hold_sf;
    logic [EXP_W-1:0] hold_exp;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready",  64'(in_ready),  64'd0);
    chk("rst_busy",      64'(busy),      64'd0);
    chk("rst_sf",        64'(out_sign_frac), 64'd0);
    chk("rst_exp",       64'(out_exp),   64'd0);
    chk("rst_ovf",       64'(out_ovf),   64'd0);
    @(negedge clk); rst = 1'b0;

    // 1: 30 - 6 = 24, exp 3+4
    begin_vec(3, 4);
    chk("t1_busy", 64'(busy), 64'd1);
    send_pair(5, 6, 1'b0);
    push_exp(1'b0, 24, 7, 1'b0);
    send_pair(-2, 3, 1'b1);
    collect("t1", 2, 1'b1);

    // 2: 600 * 16129 = 9677400 needs one right shift
    begin_vec(0, 0);
    push_exp(1'b0, 4838700, 1, 1'b0);
    for (int i = 0; i < 600; i++) send_pair(127, 127, i == 599);
    collect("t2", 3, 1'b1);

    // 3: negative result, then exact cancellation
    begin_vec(0, 0);
    push_exp(1'b1, 12, 0, 1'b0);
    send_pair(-3, 4, 1'b1);
    collect("t3a", 2, 1'b1);
    begin_vec(0, 0);
    send_pair(3, -3, 1'b0);
    push_exp(1'b0, 0, 0, 1'b0);
    send_pair(3, 3, 1'b1);
    collect("t3b", 2, 1'b1);

    // 4: exponent overflow, and largest representable exponent
    begin_vec(40, 30);
    push_exp(1'b0, 1, 63, 1'b1);
    send_pair(1, 1, 1'b1);
    collect("t4a", -1, 1'b1);
    begin_vec(63, 0);
    push_exp(1'b0, 1, 63, 1'b0);
    send_pair(1, 1, 1'b1);
    collect("t4b", -1, 1'b1);

    // 5: backpressure with an ignored start during OUT
    out_ready = 1'b0;
    begin_vec(1, 2);
    push_exp(1'b0, 20, 3, 1'b0);
    send_pair(4, 5, 1'b1);
    collect("t5", 2, 1'b0);
    hold_sf  = out_sign_frac;
    hold_exp = out_exp;
    for (int i = 0; i < 5; i++) begin
      if (i == 1) begin start = 1'b1; in_exp_a = 6'd9; in_exp_b = 6'd9; end
      @(posedge clk); #1;
      start = 1'b0;
      chk("t5_hold_valid", 64'(out_valid), 64'd1);
      chk("t5_hold_sf",    64'(out_sign_frac), 64'(hold_sf));
      chk("t5_hold_exp",   64'(out_exp),   64'(hold_exp));
      chk("t5_in_ready",   64'(in_ready),  64'd0);
    end
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1;
    chk("t5_valid_drop", 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    chk("t5_idle_busy",  64'(busy),     64'd0);
    chk("t5_idle_ready", 64'(in_ready), 64'd0);
    begin_vec(2, 2);
    push_exp(1'b1, 6, 4, 1'b0);
    send_pair(2, -3, 1'b1);
    collect("t5_next", 2, 1'b1);

    // 6: reset mid-ACCUM abandons the vector
    begin_vec(5, 5);
    for (int i = 0; i < 3; i++) send_pair(10, 10, 1'b0);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    chk("t6_valid", 64'(out_valid), 64'd0);
    chk("t6_ready", 64'(in_ready),  64'd0);
    chk("t6_busy",  64'(busy),      64'd0);
    chk("t6_sf",    64'(out_sign_frac), 64'd0);
    chk("t6_exp",   64'(out_exp),   64'd0);
    chk("t6_ovf",   64'(out_ovf),   64'd0);
    @(negedge clk); rst = 1'b0;
    begin_vec(0, 0);
    push_exp(1'b0, 4, 0, 1'b0);
    send_pair(2, 2, 1'b1);
    collect("t6_next", 2, 1'b1);

    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
